// File: rtl/io_idb_arbiter.sv
// io_idb_arbiter: round-robin owner of the 8-bit IDB output path.
// Grants one of up to four requesters at a time, muxes its byte onto IDB with
// an output enable, and inserts a one-cycle turnaround between owners.
// Optional grant-length watchdog: define IDB_ARB_TIMEOUT_EN.
module io_idb_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [3:0]  rel,
  input  logic [31:0] data_in,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic [7:0]  idb_out,
  output logic        idb_oe,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  // Reset owner is the last requester so requester 0 wins the first round.
  localparam logic [1:0] OWNER_RST = 2'(NREQ - 1);

  // Parameter legality is checked at elaboration.
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("io_idb_arbiter: NREQ must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("io_idb_arbiter: TIMEOUT must be 1..255");
  end

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic        oe_q, oe_d;
  logic [3:0]  req_m;
  logic [7:0]  data_arr [4];
  logic        any_req;
  logic [1:0]  winner;
  logic        normal_exit;

  // Requests above NREQ are masked; byte lanes are split per requester.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign req_m[gi]    = (gi < NREQ) ? req[gi] : 1'b0;
    assign data_arr[gi] = data_in[8*gi +: 8];
  end

  // Requester index k positions above base, wrapping at NREQ.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    return 2'((int'(base) + k) % NREQ);
  endfunction

  // Round-robin search starting just above the current owner.
  always_comb begin
    any_req = 1'b0;
    winner  = owner_q;
    for (int k = 1; k <= 4; k++) begin
      if (k <= NREQ && !any_req && req_m[rr_idx(owner_q, k)]) begin
        any_req = 1'b1;
        winner  = rr_idx(owner_q, k);
      end
    end
  end

  // Only the owner's own rel or req drop ends its grant.
  assign normal_exit = rel[owner_q] | ~req[owner_q];

`ifdef IDB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       terr_q, terr_d;
`endif

  // Next-state and registered-output logic for IDLE -> GRANT -> TURN.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    oe_d    = oe_q;
`ifdef IDB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        oe_d  = 1'b0;
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          oe_d    = 1'b1;
`ifdef IDB_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef IDB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (normal_exit) begin
          state_d = TURN;
          gnt_d   = 4'b0000;
          oe_d    = 1'b0;
        end
`ifdef IDB_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Forced release; owner is kept so the next round skips past it.
          state_d = TURN;
          gnt_d   = 4'b0000;
          oe_d    = 1'b0;
          terr_d  = 1'b1;
        end
`endif
      end
      TURN: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared immediately by sys_rst.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= OWNER_RST;
      oe_q    <= 1'b0;
`ifdef IDB_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      oe_q    <= oe_d;
`ifdef IDB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign idb_oe  = oe_q;
  assign busy    = (state_q != IDLE);
  assign idb_out = (state_q == GRANT) ? data_arr[owner_q] : 8'h00;
`ifdef IDB_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_idb_arbiter.sv
// Directed bench for io_idb_arbiter: reset, round-robin order, req drop,
// async reset mid-grant, grant timeout (or indefinite hold), NREQ=2 masking.
module tb_io_idb_arbiter;

  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  rel = 4'b0000;
  logic [31:0] data_in = 32'h3C96_5AA5;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  idb_out;
  logic        idb_oe, busy, timeout_err;

  logic [3:0]  req2 = 4'b1100;
  logic [3:0]  rel2 = 4'b0000;
  logic [31:0] data2 = 32'h0000_1122;
  logic [3:0]  gnt2;
  logic [1:0]  owner2;
  logic [7:0]  idb_out2;
  logic        idb_oe2, busy2, timeout_err2;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  io_idb_arbiter #(.NREQ(4), .TIMEOUT(4)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .req(req), .rel(rel), .data_in(data_in),
    .gnt(gnt), .owner(owner), .idb_out(idb_out), .idb_oe(idb_oe), .busy(busy),
    .timeout_err(timeout_err)
  );

  io_idb_arbiter #(.NREQ(2), .TIMEOUT(255)) dut2 (
    .sysclk(sysclk), .sys_rst(sys_rst), .req(req2), .rel(rel2), .data_in(data2),
    .gnt(gnt2), .owner(owner2), .idb_out(idb_out2), .idb_oe(idb_oe2), .busy(busy2),
    .timeout_err(timeout_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  logic [7:0] lane [4];

  initial begin
    lane[0] = 8'hA5; lane[1] = 8'h5A; lane[2] = 8'h96; lane[3] = 8'h3C;

    // Reset state
    step();
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_oe", idb_oe, 1'b0);
    chk("rst_out", idb_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_owner", owner, 2'd3);
    sys_rst = 1'b0;

    // Test 1: single request, one-edge latency
    req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_oe", idb_oe, 1'b1);
    chk("t1_out", idb_out, 8'hA5);
    chk("t1_owner", owner, 2'd0);
    req = 4'b0000;
    step();
    chk("t1_turn_gnt", gnt, 4'b0000);
    chk("t1_turn_oe", idb_oe, 1'b0);
    chk("t1_turn_out", idb_out, 8'h00);
    chk("t1_turn_busy", busy, 1'b1);
    step();
    chk("t1_idle_busy", busy, 1'b0);

    // Test 2: all requesting, each releases after 2 GRANT cycles -> 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_gnt%0d", i), gnt, 4'b0001 << (i % 4));
      chk($sformatf("t2_out%0d", i), idb_out, lane[i % 4]);
      step();
      chk($sformatf("t2_hold%0d", i), gnt, 4'b0001 << (i % 4));
      rel = 4'b0001 << (i % 4);
      step();
      rel = 4'b0000;
      chk($sformatf("t2_turn_gnt%0d", i), gnt, 4'b0000);
      chk($sformatf("t2_turn_oe%0d", i), idb_oe, 1'b0);
      chk($sformatf("t2_turn_busy%0d", i), busy, 1'b1);
      step();
      chk($sformatf("t2_idle_oe%0d", i), idb_oe, 1'b0);
    end
    req = 4'b0000;
    step();

    // Test 3: owner 2 drops req; requester 3 then granted
    req = 4'b0100;
    step();
    chk("t3_gnt2", gnt, 4'b0100);
    chk("t3_out2", idb_out, 8'h96);
    req = 4'b1100;
    rel = 4'b1000;
    step();
    rel = 4'b0000;
    chk("t3_nonowner_rel", gnt, 4'b0100);
    req = 4'b1000;
    step();
    chk("t3_turn_gnt", gnt, 4'b0000);
    chk("t3_turn_owner", owner, 2'd2);
    step();
    chk("t3_idle_busy", busy, 1'b0);
    step();
    chk("t3_gnt3", gnt, 4'b1000);
    chk("t3_out3", idb_out, 8'h3C);
    req = 4'b0000;
    rel = 4'b1000;
    step();
    rel = 4'b0000;
    chk("t3_relreq_turn", gnt, 4'b0000);
    step();
    chk("t3_relreq_idle", busy, 1'b0);
    step();
    chk("t3_stay_idle", busy, 1'b0);

    // Test 4: async reset during grant of owner 1
    req = 4'b0010;
    step();
    chk("t4_gnt1", gnt, 4'b0010);
    #2 sys_rst = 1'b1;
    req = 4'b0011;
    #1;
    chk("t4_async_gnt", gnt, 4'b0000);
    chk("t4_async_oe", idb_oe, 1'b0);
    chk("t4_async_owner", owner, 2'd3);
    step();
    sys_rst = 1'b0;
    step();
    chk("t4_first_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step();
    step();

    // Test 5: owner 0 holds req with no rel
    do_reset();
    req = 4'b0011;
    step();
    chk("t5_gnt0", gnt, 4'b0001);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t5_hold%0d", i), gnt, 4'b0001);
      chk($sformatf("t5_terr%0d", i), timeout_err, 1'b0);
    end
    step();
`ifdef IDB_ARB_TIMEOUT_EN
    chk("t5_to_gnt", gnt, 4'b0000);
    chk("t5_to_terr", timeout_err, 1'b1);
    chk("t5_to_owner", owner, 2'd0);
    step();
    chk("t5_idle_terr", timeout_err, 1'b0);
    step();
    chk("t5_next_gnt", gnt, 4'b0010);
`else
    chk("t5_still_gnt", gnt, 4'b0001);
    chk("t5_no_terr", timeout_err, 1'b0);
    step();
    step();
    chk("t5_still_gnt2", gnt, 4'b0001);
`endif
    req = 4'b0000;
    step();
    step();

    // Test 6: NREQ=2 ignores req[3:2]
    chk("t6_gnt", gnt2, 4'b0000);
    chk("t6_busy", busy2, 1'b0);
    chk("t6_oe", idb_oe2, 1'b0);
    req2 = 4'b0110;
    step();
    chk("t6_gnt1", gnt2, 4'b0010);
    chk("t6_out1", idb_out2, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
